// File: rtl/io_deco.sv
// -----------------------------------------------------------------------------
// io_deco : memory-mapped I/O address decoder
//
// Turns the 22-bit word address from the datapath into one-hot region selects
// for the data RAM, the original/processed image buffers and the two display
// control registers, plus a 2-bit index into the 4-word button window.
// All outputs are registered, so a decode appears one clock after the address.
//
// Ports
//   clk               in   1       system clock, rising edge
//   rst               in   1       synchronous active-high reset, clears outputs
//   direction         in   ADDR_W  word address from the ALU / datapath
//   mem_enb           out  1       data RAM select
//   show_enb          out  1       "show processed image" register select
//   show_original_enb out  1       "show original image" register select
//   original_enb      out  1       original-image buffer select
//   process_enb       out  1       processed-image buffer select
//   btn_selecc        out  2       button index inside the button window, else 0
// -----------------------------------------------------------------------------
module io_deco #(
    parameter int unsigned             ADDR_W         = 22,
    parameter logic [ADDR_W-1:0]       MEM_TOP        = 22'h0FFFFF,
    parameter logic [ADDR_W-1:0]       ORIG_BASE      = 22'h100000,
    parameter logic [ADDR_W-1:0]       PROC_BASE      = 22'h200000,
    parameter logic [ADDR_W-1:0]       SHOW_ADDR      = 22'h3FFFF0,
    parameter logic [ADDR_W-1:0]       SHOW_ORIG_ADDR = 22'h3FFFF1,
    parameter logic [ADDR_W-1:0]       BTN_BASE       = 22'h3FFFF4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] direction,
    output logic              mem_enb,
    output logic              show_enb,
    output logic              show_original_enb,
    output logic              original_enb,
    output logic              process_enb,
    output logic [1:0]        btn_selecc
);

    // Both image buffers span 1M words; last offset inside a buffer.
    localparam logic [ADDR_W-1:0] REGION_LAST = {{(ADDR_W-20){1'b0}}, 20'hFFFFF};
    localparam logic [ADDR_W-1:0] ORIG_TOP    = ORIG_BASE + REGION_LAST;
    localparam logic [ADDR_W-1:0] PROC_TOP    = PROC_BASE + REGION_LAST;
    localparam logic [ADDR_W-1:0] BTN_TOP     = BTN_BASE + {{(ADDR_W-2){1'b0}}, 2'd3};

    logic       mem_enb_d, show_enb_d, show_orig_enb_d, orig_enb_d, proc_enb_d;
    logic [1:0] btn_sel_d;

    logic       mem_enb_q, show_enb_q, show_orig_enb_q, orig_enb_q, proc_enb_q;
    logic [1:0] btn_sel_q;

    // Combinational decode. The regions are disjoint, so at most one enable
    // can be raised for any address.
    always_comb begin
        mem_enb_d       = 1'b0;
        show_enb_d      = 1'b0;
        show_orig_enb_d = 1'b0;
        orig_enb_d      = 1'b0;
        proc_enb_d      = 1'b0;
        btn_sel_d       = 2'b00;

        if (direction <= MEM_TOP) begin
            mem_enb_d = 1'b1;
        end else if (direction >= ORIG_BASE && direction <= ORIG_TOP) begin
            orig_enb_d = 1'b1;
        end else if (direction >= PROC_BASE && direction <= PROC_TOP) begin
            proc_enb_d = 1'b1;
        end else if (direction == SHOW_ADDR) begin
            show_enb_d = 1'b1;
        end else if (direction == SHOW_ORIG_ADDR) begin
            show_orig_enb_d = 1'b1;
        end else if (direction >= BTN_BASE && direction <= BTN_TOP) begin
            // BTN_BASE is 4-word aligned, so the low address bits are the
            // button index directly. No enable accompanies this window.
            btn_sel_d = direction[1:0];
        end
    end

    // Output registers: one cycle of latency to line up with the synchronous
    // memories and the display controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_enb_q       <= 1'b0;
            show_enb_q      <= 1'b0;
            show_orig_enb_q <= 1'b0;
            orig_enb_q      <= 1'b0;
            proc_enb_q      <= 1'b0;
            btn_sel_q       <= 2'b00;
        end else begin
            mem_enb_q       <= mem_enb_d;
            show_enb_q      <= show_enb_d;
            show_orig_enb_q <= show_orig_enb_d;
            orig_enb_q      <= orig_enb_d;
            proc_enb_q      <= proc_enb_d;
            btn_sel_q       <= btn_sel_d;
        end
    end

    assign mem_enb           = mem_enb_q;
    assign show_enb          = show_enb_q;
    assign show_original_enb = show_orig_enb_q;
    assign original_enb      = orig_enb_q;
    assign process_enb       = proc_enb_q;
    assign btn_selecc        = btn_sel_q;

endmodule

// File: tb/tb_io_deco.sv
// -----------------------------------------------------------------------------
// tb_io_deco : self-checking bench for io_deco
//
// A reference model computes the expected output vector from the address map
// with plain range arithmetic; a compare process checks the DUT against it on
// every falling edge. Directed vectors additionally check hand-written literal
// output vectors. Output vector packing: {mem, show, show_orig, orig, proc, btn[1:0]}.
// -----------------------------------------------------------------------------
module tb_io_deco;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] direction = 22'd50;
    logic        mem_enb, show_enb, show_original_enb, original_enb, process_enb;
    logic [1:0]  btn_selecc;

    int checks = 0;
    int errors = 0;

    io_deco dut (
        .clk               (clk),
        .rst               (rst),
        .direction         (direction),
        .mem_enb           (mem_enb),
        .show_enb          (show_enb),
        .show_original_enb (show_original_enb),
        .original_enb      (original_enb),
        .process_enb       (process_enb),
        .btn_selecc        (btn_selecc)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dut_vec();
        return {mem_enb, show_enb, show_original_enb, original_enb, process_enb, btn_selecc};
    endfunction

    // Reference model: output vector straight from the address map.
    function automatic logic [6:0] model(input logic [21:0] a);
        int unsigned u;
        int unsigned off;
        u = int'(a);
        if (u < 32'h100000)                        return 7'b1000000;
        if (u < 32'h200000)                        return 7'b0001000;
        if (u < 32'h300000)                        return 7'b0000100;
        if (u == 32'h3FFFF0)                       return 7'b0100000;
        if (u == 32'h3FFFF1)                       return 7'b0010000;
        if (u >= 32'h3FFFF4 && u < 32'h3FFFF8) begin
            off = u - 32'h3FFFF4;
            return {5'b00000, off[1:0]};
        end
        return 7'b0000000;
    endfunction

    // Model state: expected outputs after each rising edge.
    logic [6:0] exp_vec;
    bit         model_vld = 1'b0;

    always @(posedge clk) begin
        exp_vec   = rst ? 7'b0000000 : model(direction);
        model_vld = 1'b1;
    end

    // Per-cycle compare against the model plus the exclusivity property.
    always @(negedge clk) begin
        if (model_vld) begin
            checks++;
            if (dut_vec() !== exp_vec) begin
                errors++;
                $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, dut_vec(), exp_vec);
            end
            checks++;
            if ($countones({mem_enb, show_enb, show_original_enb, original_enb, process_enb}) > 1) begin
                errors++;
                $display("FAIL onehot t=%0t got=%b exp=at_most_one_enable", $time, dut_vec());
            end
        end
    end

    // Drive one address (and reset level) for one edge, then sample just after it.
    task automatic apply(input logic [21:0] a, input logic r);
        @(negedge clk);
        direction = a;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] exp);
        checks++;
        if (dut_vec() !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, dut_vec(), exp);
        end
    endtask

    typedef struct {
        logic [21:0] a;
        logic        r;
        logic [6:0]  e;
        string       name;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // Reset held two cycles with an in-RAM address, then released.
        vecs.push_back('{22'd50,     1'b1, 7'b0000000, "reset_1"});
        vecs.push_back('{22'd50,     1'b1, 7'b0000000, "reset_2"});
        vecs.push_back('{22'd50,     1'b0, 7'b1000000, "first_decode"});
        // Region boundaries.
        vecs.push_back('{22'h0FFFFF, 1'b0, 7'b1000000, "mem_top"});
        vecs.push_back('{22'h100000, 1'b0, 7'b0001000, "orig_base"});
        vecs.push_back('{22'h1FFFFF, 1'b0, 7'b0001000, "orig_top"});
        vecs.push_back('{22'h200000, 1'b0, 7'b0000100, "proc_base"});
        vecs.push_back('{22'h2FFFFF, 1'b0, 7'b0000100, "proc_top"});
        vecs.push_back('{22'h300000, 1'b0, 7'b0000000, "hole_base"});
        vecs.push_back('{22'h3FFFEF, 1'b0, 7'b0000000, "hole_top"});
        // Control registers and the gap after them.
        vecs.push_back('{22'h3FFFF0, 1'b0, 7'b0100000, "show"});
        vecs.push_back('{22'h3FFFF1, 1'b0, 7'b0010000, "show_orig"});
        vecs.push_back('{22'h3FFFF2, 1'b0, 7'b0000000, "gap_f2"});
        vecs.push_back('{22'h3FFFF3, 1'b0, 7'b0000000, "gap_f3"});
        // Button window and beyond.
        vecs.push_back('{22'h3FFFF4, 1'b0, 7'b0000000, "btn0"});
        vecs.push_back('{22'h3FFFF5, 1'b0, 7'b0000001, "btn1"});
        vecs.push_back('{22'h3FFFF6, 1'b0, 7'b0000010, "btn2"});
        vecs.push_back('{22'h3FFFF7, 1'b0, 7'b0000011, "btn3"});
        vecs.push_back('{22'h3FFFF8, 1'b0, 7'b0000000, "btn_past"});
        vecs.push_back('{22'h3FFFFF, 1'b0, 7'b0000000, "addr_max"});
        // Back-to-back changes, then reset asserted mid-stream.
        vecs.push_back('{22'd50,     1'b0, 7'b1000000, "seq_mem"});
        vecs.push_back('{22'h150000, 1'b0, 7'b0001000, "seq_orig"});
        vecs.push_back('{22'h3FFFF6, 1'b0, 7'b0000010, "seq_btn"});
        vecs.push_back('{22'h250000, 1'b1, 7'b0000000, "seq_rst"});
        vecs.push_back('{22'h250000, 1'b0, 7'b0000100, "seq_after_rst"});

        foreach (vecs[i]) begin
            apply(vecs[i].a, vecs[i].r);
            chk(vecs[i].name, vecs[i].e);
        end

        // Pin the model itself against a few hand-computed vectors.
        checks++;
        if (model(22'h3FFFF7) !== 7'b0000011) begin
            errors++;
            $display("FAIL model_pin_btn3 got=%b exp=%b", model(22'h3FFFF7), 7'b0000011);
        end
        checks++;
        if (model(22'h100000) !== 7'b0001000) begin
            errors++;
            $display("FAIL model_pin_orig got=%b exp=%b", model(22'h100000), 7'b0001000);
        end

        // Random traffic, biased toward the dense control area at the top.
        for (int n = 0; n < 10000; n++) begin
            logic [21:0] a;
            logic        r;
            if ($urandom_range(0, 3) == 0)
                a = 22'h3FFFF0 + 22'($urandom_range(0, 15));
            else
                a = 22'($urandom);
            r = ($urandom_range(0, 99) == 0);
            apply(a, r);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
